// File: rtl/disp_page_sched.sv
// Page scheduler sharing the two-digit readout between seq/freq/rom values.
// Optional freeze-blink on disp_blank: define DISP_SCHED_BLINK_EN.
module disp_page_sched #(
    parameter int DEB_CYCLES   = 1000000,
    parameter int ROT_CYCLES   = 150000000,
    parameter int REFR_CYCLES  = 5000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    input  logic [6:0] seq_num,
    input  logic [6:0] freq_num,
    input  logic [6:0] rom_addr,
    output logic [6:0] disp_val,
    output logic       disp_blank,
    output logic [1:0] page,
    output logic [2:0] page_onehot,
    output logic       auto_mode,
    output logic       frozen,
    output logic       ovf
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(ROT_CYCLES + 1);
    localparam int FW = $clog2(REFR_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_CYCLES - 1);
    localparam logic [FW-1:0] REFR_LAST = FW'(REFR_CYCLES - 1);

    if (DEB_CYCLES < 1 || ROT_CYCLES < 1 || REFR_CYCLES < 1 ||
        BLINK_CYCLES < 1) begin : g_bad_param
        $error("disp_page_sched: cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        PG_SEQ  = 2'd0,
        PG_FREQ = 2'd1,
        PG_ROM  = 2'd2
    } pg_t;

    logic [2:0]    w_keys;
    logic [2:0]    r_s1;
    logic [2:0]    r_s2;
    logic [2:0]    r_stb;
    logic [DW-1:0] r_deb [3];
    logic [2:0]    w_press;

    pg_t           r_pg;
    pg_t           w_pg_nxt;
    logic          r_auto;
    logic          r_frozen;
    logic          r_unfrz;
    logic [RW-1:0] r_rot;
    logic [FW-1:0] r_refr;
    logic [6:0]    r_val;
    logic          r_ovf;
    logic [6:0]    w_src;
    logic          w_tick;
    logic          w_adv;
    logic          w_frz_nxt;
    logic          w_load;

    assign w_keys = {KEY3, KEY2, KEY1};

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_s1  <= '1;
            r_s2  <= '1;
            r_stb <= '1;
            for (int i = 0; i < 3; i++) r_deb[i] <= '0;
        end else begin
            r_s1 <= w_keys;
            r_s2 <= r_s1;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_stb[i]) begin
                    r_deb[i] <= '0;
                end else if (r_deb[i] == DEB_LAST) begin
                    r_deb[i] <= '0;
                    r_stb[i] <= r_s2[i];
                end else begin
                    r_deb[i] <= r_deb[i] + 1'b1;
                end
            end
        end
    end

    // Press fires in the cycle the stable level is about to fall.
    always_comb begin
        w_press = '0;
        for (int i = 0; i < 3; i++)
            w_press[i] = r_stb[i] & ~r_s2[i] & (r_deb[i] == DEB_LAST);
    end

    assign w_tick    = r_auto & (r_rot == ROT_LAST);
    assign w_adv     = ~r_frozen & ~w_press[2] & (w_press[0] | w_tick);
    assign w_frz_nxt = r_frozen ^ w_press[2];
    assign w_load    = ~r_frozen & ((r_refr == REFR_LAST) | w_adv | r_unfrz);

    always_comb begin
        w_pg_nxt = PG_SEQ;
        case (r_pg)
            PG_SEQ:  w_pg_nxt = w_adv ? PG_FREQ : PG_SEQ;
            PG_FREQ: w_pg_nxt = w_adv ? PG_ROM  : PG_FREQ;
            PG_ROM:  w_pg_nxt = w_adv ? PG_SEQ  : PG_ROM;
            default: w_pg_nxt = PG_SEQ;
        endcase
        w_src = seq_num;
        case (w_pg_nxt)
            PG_FREQ: w_src = freq_num;
            PG_ROM:  w_src = rom_addr;
            default: w_src = seq_num;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_pg     <= PG_SEQ;
            r_auto   <= 1'b0;
            r_frozen <= 1'b0;
            r_unfrz  <= 1'b0;
            r_rot    <= '0;
            r_refr   <= '0;
            r_val    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_pg     <= w_pg_nxt;
            r_auto   <= r_auto ^ w_press[1];
            r_frozen <= w_frz_nxt;
            r_unfrz  <= r_frozen & w_press[2];
            if (w_adv | w_press[1] | ~r_auto)
                r_rot <= '0;
            else if (!(r_frozen | w_press[2]))
                r_rot <= r_rot + 1'b1;
            if (!r_frozen)
                r_refr <= w_load ? '0 : r_refr + 1'b1;
            if (w_load) begin
                r_val <= (w_src > 7'd99) ? 7'd99 : w_src;
                r_ovf <= (w_src > 7'd99);
            end
        end
    end

`ifdef DISP_SCHED_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] r_blk;
    logic          r_blank;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_blk   <= '0;
            r_blank <= 1'b0;
        end else if (!w_frz_nxt) begin
            r_blk   <= '0;
            r_blank <= 1'b0;
        end else if (r_frozen) begin
            if (r_blk == BLINK_LAST) begin
                r_blk   <= '0;
                r_blank <= ~r_blank;
            end else begin
                r_blk <= r_blk + 1'b1;
            end
        end
    end

    assign disp_blank = r_blank;
`else
    assign disp_blank = 1'b0;
`endif

    assign disp_val    = r_val;
    assign ovf         = r_ovf;
    assign page        = r_pg;
    assign page_onehot = {r_pg == PG_ROM, r_pg == PG_FREQ, r_pg == PG_SEQ};
    assign auto_mode   = r_auto;
    assign frozen      = r_frozen;

endmodule

// File: tb/tb_disp_page_sched.sv
// Scoreboard bench for disp_page_sched with short debounce/rotate/refresh windows.
module tb_disp_page_sched;
    localparam int DEB   = 4;
    localparam int ROT   = 20;
    localparam int REFR  = 8;
    localparam int BLINK = 5;
    localparam int LAT   = 2 + DEB;

    typedef struct {
        string tag;
        int    dv;
        int    pg;
        int    ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       key0, key1, key2, key3;
    logic [6:0] seq_num, freq_num, rom_addr;
    logic [6:0] disp_val;
    logic       disp_blank;
    logic [1:0] page;
    logic [2:0] page_onehot;
    logic       auto_mode, frozen, ovf;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    disp_page_sched #(
        .DEB_CYCLES  (DEB),
        .ROT_CYCLES  (ROT),
        .REFR_CYCLES (REFR),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .CLOCK_50   (clk),
        .KEY0       (key0),
        .KEY1       (key1),
        .KEY2       (key2),
        .KEY3       (key3),
        .seq_num    (seq_num),
        .freq_num   (freq_num),
        .rom_addr   (rom_addr),
        .disp_val   (disp_val),
        .disp_blank (disp_blank),
        .page       (page),
        .page_onehot(page_onehot),
        .auto_mode  (auto_mode),
        .frozen     (frozen),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1:       key1 = v;
            2:       key2 = v;
            default: key3 = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b0);
        tick(LAT);
        set_key(k, 1'b1);
    endtask

    task automatic sb_push(input string tag, input int dv, input int pg,
                           input int ov);
        exp_t e;
        e.tag = tag;
        e.dv  = dv;
        e.pg  = pg;
        e.ov  = ov;
        sb.push_back(e);
    endtask

    task automatic sb_cmp();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, "_val"},  32'(disp_val),    e.dv);
        chk({e.tag, "_page"}, 32'(page),        e.pg);
        chk({e.tag, "_oh"},   32'(page_onehot), 1 << e.pg);
        chk({e.tag, "_ovf"},  32'(ovf),         e.ov);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        key0 = 1'b0; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        seq_num = 7'd42; freq_num = 7'd17; rom_addr = 7'd33;

        // reset and first refresh
        tick(3);
        sb_push("reset", 0, 0, 0); sb_cmp();
        chk("rst_auto",  32'(auto_mode),  0);
        chk("rst_frz",   32'(frozen),     0);
        chk("rst_blank", 32'(disp_blank), 0);
        key0 = 1'b1;
        tick(REFR - 1);
        sb_push("pre_refr", 0, 0, 0); sb_cmp();
        tick(1);
        sb_push("first_refr", 42, 0, 0); sb_cmp();

        // manual advance and short bounce
        set_key(1, 1'b0);
        sb_push("k1_adv", 17, 1, 0);
        tick(LAT - 1);
        chk("k1_lat_page", 32'(page), 0);
        tick(1);
        sb_cmp();
        tick(10 - LAT);
        set_key(1, 1'b1);
        tick(8);
        set_key(1, 1'b0);
        tick(2);
        set_key(1, 1'b1);
        sb_push("k1_bounce", 17, 1, 0);
        tick(10);
        sb_cmp();

        // auto rotation
        press(2);
        chk("auto_on", 32'(auto_mode), 1);
        tick(ROT - 1);
        sb_push("dwell_end", 17, 1, 0); sb_cmp();
        tick(1);
        sb_push("rot_1_2", 33, 2, 0); sb_cmp();
        tick(ROT);
        sb_push("rot_2_0", 42, 0, 0); sb_cmp();
        tick(ROT);
        sb_push("rot_0_1", 17, 1, 0); sb_cmp();
        tick(5);
        sb_push("k1_mid", 33, 2, 0);
        press(1);
        sb_cmp();
        tick(ROT - 1);
        sb_push("fresh_dwell", 33, 2, 0); sb_cmp();
        tick(1);
        sb_push("fresh_adv", 42, 0, 0); sb_cmp();
        press(2);
        chk("auto_off", 32'(auto_mode), 0);
        tick(7);

        // saturation and overflow flag
        press(1);
        sb_push("to_freq", 17, 1, 0); sb_cmp();
        tick(7);
        rom_addr = 7'd127;
        press(1);
        sb_push("rom_sat", 99, 2, 1); sb_cmp();
        rom_addr = 7'd99;
        tick(REFR - 1);
        sb_push("rom99_pre", 99, 2, 1); sb_cmp();
        tick(1);
        sb_push("rom99", 99, 2, 0); sb_cmp();
        rom_addr = 7'd0;
        tick(REFR);
        sb_push("rom0", 0, 2, 0); sb_cmp();

        // freeze and unfreeze
        seq_num = 7'd5;
        press(1);
        sb_push("seq5", 5, 0, 0); sb_cmp();
        tick(7);
        press(3);
        chk("frz_on", 32'(frozen), 1);
`ifdef DISP_SCHED_BLINK_EN
        chk("blink_start", 32'(disp_blank), 0);
        tick(BLINK - 1);
        chk("blink_pre", 32'(disp_blank), 0);
        tick(1);
        chk("blink_tog", 32'(disp_blank), 1);
`endif
        tick(7);
        seq_num = 7'd60;
        press(1);
        tick(7);
        sb_push("frz_hold", 5, 0, 0); sb_cmp();
        tick(10);
        sb_push("frz_norefr", 5, 0, 0); sb_cmp();
        press(3);
        chk("frz_off", 32'(frozen), 0);
        sb_push("unfrz_edge", 5, 0, 0); sb_cmp();
`ifdef DISP_SCHED_BLINK_EN
        chk("blink_clr", 32'(disp_blank), 0);
`endif
        tick(1);
        sb_push("unfrz_load", 60, 0, 0); sb_cmp();
        tick(7);

        // frozen + auto on page 2, then async reset
        press(1);
        sb_push("to_freq2", 17, 1, 0); sb_cmp();
        tick(7);
        rom_addr = 7'd77;
        press(1);
        sb_push("to_rom2", 77, 2, 0); sb_cmp();
        tick(7);
        key2 = 1'b0;
        key3 = 1'b0;
        tick(LAT);
        key2 = 1'b1;
        key3 = 1'b1;
        chk("both_auto", 32'(auto_mode), 1);
        chk("both_frz",  32'(frozen),    1);
        sb_push("both_keys", 77, 2, 0); sb_cmp();
        tick(7);
        #4;
        key0 = 1'b0;
        #1;
        sb_push("async_rst", 0, 0, 0); sb_cmp();
        chk("arst_auto",  32'(auto_mode),  0);
        chk("arst_frz",   32'(frozen),     0);
        chk("arst_blank", 32'(disp_blank), 0);
        #2;
        key0 = 1'b1;
        tick(20);
        chk("post_auto", 32'(auto_mode), 0);
        chk("post_frz",  32'(frozen),    0);
        sb_push("post_rst", 60, 0, 0); sb_cmp();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
